// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared types and defaults for the UART transmit arbiter.
package uart_arb_pkg;

  localparam int BYTE_W             = 8;
  localparam int ID_W               = 3;
  localparam int DEF_NUM_REQ        = 4;
  localparam int DEF_TIMEOUT_CYCLES = 65535;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_LAUNCH      = 3'd1,
    ST_WAIT_ACTIVE = 3'd2,
    ST_WAIT_DONE   = 3'd3,
    ST_ACK         = 3'd4
  } arb_state_t;

endpackage

// File: rtl/uart_rr_picker.sv
// uart_rr_picker: combinational round-robin winner selection.
// The search starts at the index after last_owner and wraps at NUM_REQ-1.
module uart_rr_picker
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_owner,
  output logic               any_req,
  output logic [ID_W-1:0]    winner
);

  logic found;
  int   idx;

  // first requester found when scanning upward from last_owner+1
  always_comb begin
    any_req = |req;
    winner  = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(last_owner) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between NUM_REQ byte requesters.
// Optional watchdog: define UART_ARB_TIMEOUT_EN to abort transfers that never
// complete after TIMEOUT_CYCLES clk cycles (reported through timeout_err).
//
// state          | meaning
// ST_IDLE        | no transfer; pick a winner when any req is high
// ST_LAUNCH      | one-cycle uart_send pulse with the captured byte
// ST_WAIT_ACTIVE | waiting for the driver to report tx_active (or tx_done)
// ST_WAIT_DONE   | driver busy; waiting for tx_done
// ST_ACK         | one-cycle ack to the owner, owner becomes last_owner
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      uart_send,
  output logic [BYTE_W-1:0]         uart_data,
  input  logic                      uart_tx_active,
  input  logic                      uart_tx_done,
  output logic                      busy,
  output logic [ID_W-1:0]           grant_id,
  output logic                      timeout_err
);

  arb_state_t        state, state_nxt;
  logic              any_req;
  logic [ID_W-1:0]   winner;
  logic [ID_W-1:0]   last_owner;
  logic [ID_W-1:0]   grant_q;
  logic [BYTE_W-1:0] data_q;
  logic              wd_hit;

  uart_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req        (req),
    .last_owner (last_owner),
    .any_req    (any_req),
    .winner     (winner)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // next-state logic; tx_done wins over tx_active in WAIT_ACTIVE
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:        if (any_req) state_nxt = ST_LAUNCH;
      ST_LAUNCH:      state_nxt = ST_WAIT_ACTIVE;
      ST_WAIT_ACTIVE: begin
        if (uart_tx_done || wd_hit) state_nxt = ST_ACK;
        else if (uart_tx_active)    state_nxt = ST_WAIT_DONE;
      end
      ST_WAIT_DONE:   if (uart_tx_done || wd_hit) state_nxt = ST_ACK;
      ST_ACK:         state_nxt = ST_IDLE;
      default:        state_nxt = ST_IDLE;
    endcase
  end

  // outputs decoded from the current state
  always_comb begin
    uart_send = (state == ST_LAUNCH);
    busy      = (state != ST_IDLE);
    ack       = '0;
    if (state == ST_ACK) ack = NUM_REQ'(1) << grant_q;
  end

  // capture owner and byte at grant time, remember the owner at ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q    <= '0;
      data_q     <= '0;
      last_owner <= ID_W'(NUM_REQ - 1);
    end else begin
      if (state == ST_IDLE && any_req) begin
        grant_q <= winner;
        data_q  <= req_data[BYTE_W*int'(winner) +: BYTE_W];
      end
      if (state == ST_ACK) last_owner <= grant_q;
    end
  end

  assign uart_data = data_q;
  assign grant_id  = grant_q;

`ifdef UART_ARB_TIMEOUT_EN
  logic [15:0] wd_cnt;
  logic        waiting;
  logic        to_flag;

  assign waiting = (state == ST_WAIT_ACTIVE) || (state == ST_WAIT_DONE);
  // counter reads TIMEOUT_CYCLES-2 in the last wait cycle, so the forced ACK
  // lands exactly TIMEOUT_CYCLES cycles after the LAUNCH cycle
  assign wd_hit  = waiting && (wd_cnt == 16'(TIMEOUT_CYCLES - 2));

  // watchdog count and abort flag; the flag is only ever high in ACK
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt  <= '0;
      to_flag <= 1'b0;
    end else begin
      if (state == ST_IDLE && any_req) wd_cnt <= '0;
      else if (waiting)                wd_cnt <= wd_cnt + 16'd1;
      to_flag <= wd_hit && !uart_tx_done;
    end
  end

  assign timeout_err = to_flag;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign wd_hit             = 1'b0;
  assign timeout_err        = 1'b0;
`endif

endmodule
